// File: rtl/rd_dst_tracker_pkg.sv
// Shared switch package for the read-destination tracker.
// Holds the default field widths, the packed command-payload layout and a
// helper that computes the flat command-payload width for any width choice.
// The command payload is laid out LSB-first as {msg, dstPort, drop}:
//   drop    : bit 0
//   dstPort : bits [DST_W:1]
//   msg     : bits [ADDR_W+4+DST_W:DST_W+1]
// ADDR_LENTH and DATA_WIDTH are normally supplied by the wider codebase; they
// fall back to local defaults so this slice elaborates on its own.

`ifndef ADDR_LENTH
`define ADDR_LENTH 16
`endif

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package rd_dst_tracker_pkg;

    localparam int RD_DST_W  = 4;
    localparam int RD_ADDR_W = `ADDR_LENTH;
    localparam int RD_DATA_W = `DATA_WIDTH;
    localparam int RD_MSG_W  = RD_ADDR_W + 4;

    typedef struct packed {
        logic [RD_MSG_W-1:0] msg;
        logic [RD_DST_W-1:0] dstPort;
        logic                drop;
    } rdCmdPld_t;

    localparam int RD_CMD_PLD_W = $bits(rdCmdPld_t);

    // Flat command-payload width for non-default parameterisations.
    function automatic int cmdPldW(input int addrW, input int dstW);
        return addrW + 4 + dstW + 1;
    endfunction

endpackage

// File: rtl/rd_dst_fifo.sv
// Destination FIFO for the read-destination tracker.
// DEPTH entries of DST_W bits, wrapping read/write pointers, occupancy count
// 0..DEPTH. The head entry is presented combinationally from the storage, so
// a freshly pushed entry into an empty FIFO becomes visible one cycle later.
// Ports:
//   iClk, iRst_n      : clock, asynchronous active-low reset
//   iPush, iPushDst   : write one destination (caller guarantees !oFull)
//   iPop              : drop the head entry (caller guarantees !oEmpty)
//   oHead             : current head destination
//   oFull, oEmpty     : occupancy flags
//   oCount            : number of stored entries

module rd_dst_fifo #(
    parameter  int DST_W = 4,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iPush,
    input  logic [DST_W-1:0] iPushDst,
    input  logic             iPop,
    output logic [DST_W-1:0] oHead,
    output logic             oFull,
    output logic             oEmpty,
    output logic [CNT_W-1:0] oCount
);

    logic [DST_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] countNext;

    always_comb begin
        countNext = count;
        case ({iPush, iPop})
            2'b10:   countNext = count + CNT_W'(1);
            2'b01:   countNext = count - CNT_W'(1);
            default: countNext = count;   // idle, or push+pop cancel out
        endcase
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (iPush) wrPtr <= wrPtr + PTR_W'(1);
            if (iPop)  rdPtr <= rdPtr + PTR_W'(1);
            count <= countNext;
        end
    end

    // Contents are cleared on reset so the idle head reads as destination 0.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (iPush) begin
            mem[wrPtr] <= iPushDst;
        end
    end

    assign oHead  = mem[rdPtr];
    assign oFull  = (count == CNT_W'(DEPTH));
    assign oEmpty = (count == '0);
    assign oCount = count;

endmodule

// File: rtl/rd_dst_tracker.sv
// Read-destination tracker.
// Commands heading to the memory side carry a destination port; read data
// coming back does not. Each non-dropped command pushes its destination into
// an in-order FIFO, and every returning burst is tagged with the head
// destination, which is retired on the burst's last beat. Payloads pass
// straight through with no added latency.
// Optional feature (macro RD_DST_ORPHAN_DROP_EN): data arriving while nothing
// is outstanding is swallowed and flagged on a sticky oOrphanErr output;
// without the macro such data simply stalls and the flag port does not exist.
// Ports:
//   iClk, iRst_n                         : clock, asynchronous active-low reset
//   iRdCmdIn{Vld,Pld} / oRdCmdInRdy      : command in  {msg, dstPort, drop}
//   oRdCmdOut{Vld,Pld,Dst} / iRdCmdOutRdy: command out to memory side
//   iRdDataIn{Vld,Pld} / oRdDataInRdy    : read data in {data, last}
//   oRdDataOut{Vld,Pld,Dst}/iRdDataOutRdy: read data out with tracked Dst
//   oOrphanErr                           : sticky orphan flag (macro only)
//   oOcc                                 : outstanding tracked commands

module rd_dst_tracker
    import rd_dst_tracker_pkg::*;
#(
    parameter  int DST_W  = RD_DST_W,
    parameter  int ADDR_W = RD_ADDR_W,
    parameter  int DATA_W = RD_DATA_W,
    parameter  int DEPTH  = 4,
    localparam int CMD_W  = cmdPldW(ADDR_W, DST_W),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              iClk,
    input  logic              iRst_n,

    input  logic              iRdCmdInVld,
    input  logic [CMD_W-1:0]  iRdCmdInPld,
    output logic              oRdCmdInRdy,

    output logic              oRdCmdOutVld,
    output logic [CMD_W-1:0]  oRdCmdOutPld,
    output logic [DST_W-1:0]  oRdCmdOutDst,
    input  logic              iRdCmdOutRdy,

    input  logic              iRdDataInVld,
    input  logic [DATA_W:0]   iRdDataInPld,
    output logic              oRdDataInRdy,

    output logic              oRdDataOutVld,
    output logic [DATA_W:0]   oRdDataOutPld,
    output logic [DST_W-1:0]  oRdDataOutDst,
    input  logic              iRdDataOutRdy,

`ifdef RD_DST_ORPHAN_DROP_EN
    output logic              oOrphanErr,
`endif
    output logic [CNT_W-1:0]  oOcc
);

    logic             cmdDrop;
    logic [DST_W-1:0] cmdDst;
    logic             dataLast;
    logic             fifoFull;
    logic             fifoEmpty;
    logic [DST_W-1:0] fifoHead;
    logic             fifoPush;
    logic             fifoPop;

    assign cmdDrop  = iRdCmdInPld[0];
    assign cmdDst   = iRdCmdInPld[DST_W:1];
    assign dataLast = iRdDataInPld[0];

    // Command side: gated only by the registered full flag, so a pop in the
    // same cycle cannot combinationally open the command path. Dropped
    // commands are gated identically even though they never push.
    assign oRdCmdOutVld = iRdCmdInVld & ~fifoFull;
    assign oRdCmdInRdy  = iRdCmdOutRdy & ~fifoFull;
    assign oRdCmdOutPld = iRdCmdInPld;
    assign oRdCmdOutDst = cmdDst;
    assign fifoPush     = iRdCmdInVld & iRdCmdOutRdy & ~fifoFull & ~cmdDrop;

    // Data side: forward only while a destination is outstanding.
    assign oRdDataOutVld = iRdDataInVld & ~fifoEmpty;
    assign oRdDataOutPld = iRdDataInPld;
    assign oRdDataOutDst = fifoHead;
    assign fifoPop       = iRdDataInVld & iRdDataOutRdy & ~fifoEmpty & dataLast;

`ifdef RD_DST_ORPHAN_DROP_EN
    // Orphan beats are accepted and discarded rather than stalling the
    // return path; the event is remembered until reset.
    assign oRdDataInRdy = fifoEmpty ? 1'b1 : iRdDataOutRdy;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oOrphanErr <= 1'b0;
        end else if (iRdDataInVld && fifoEmpty) begin
            oOrphanErr <= 1'b1;
        end
    end
`else
    assign oRdDataInRdy = iRdDataOutRdy & ~fifoEmpty;
`endif

    rd_dst_fifo #(
        .DST_W (DST_W),
        .DEPTH (DEPTH)
    ) uDstFifo (
        .iClk     (iClk),
        .iRst_n   (iRst_n),
        .iPush    (fifoPush),
        .iPushDst (cmdDst),
        .iPop     (fifoPop),
        .oHead    (fifoHead),
        .oFull    (fifoFull),
        .oEmpty   (fifoEmpty),
        .oCount   (oOcc)
    );

endmodule

// File: doc/rd_dst_tracker.md
RD_DST_TRACKER -- requirements
Module: rd_dst_tracker

Interface
REQ-001 Parameter DST_W, default 4: width of the destination port field in command payloads and in oRdDataOut.Dst.
REQ-002 Parameter ADDR_W, default `ADDR_LENTH: width of the command message field.
REQ-003 Parameter DATA_W, default `DATA_WIDTH: width of the read data word.
REQ-004 Parameter DEPTH, default 4: maximum outstanding non-dropped read commands; power of two, 2..16.
REQ-005 iClk  input  1  clock, all state on rising edge.
REQ-006 iRst_n  input  1  asynchronous, active-low reset.
REQ-007 iRdCmdIn  Decoupled.slave  -  command in; Pld = {msg[ADDR_W+4-1:0], dstPort[DST_W-1:0], drop}.
REQ-008 oRdCmdOut  Decoupled.master  -  command out to memory side; Pld and Dst copied from iRdCmdIn.
REQ-009 iRdDataIn  Decoupled.slave  -  read data in; Pld = {data[DATA_W-1:0], last}; carries no destination.
REQ-010 oRdDataOut  Decoupled.master  -  read data out; Pld copied from iRdDataIn, Dst = tracked destination.
REQ-011 oOcc  output  $clog2(DEPTH)+1  number of outstanding tracked commands.
REQ-012 oOrphanErr  output  1  sticky orphan-data flag; present only with RD_DST_ORPHAN_DROP_EN.

Function
REQ-013 The block SHALL hold a DEPTH-entry FIFO of DST_W-bit destinations, with wrapping read/write pointers and a count of 0..DEPTH.
- full: count == DEPTH.
- empty: count == 0.
REQ-014 The block SHALL assert oRdCmdOut.Vld = iRdCmdIn.Vld & !full and iRdCmdIn.Rdy = oRdCmdOut.Rdy & !full; dropped commands are gated the same way.
REQ-015 The block SHALL push dstPort on a command handshake with drop == 0; a command with drop == 1 SHALL pass downstream without a push.
REQ-016 The block SHALL drive oRdDataOut.Dst = FIFO head entry, oRdDataOut.Vld = iRdDataIn.Vld & !empty, and iRdDataIn.Rdy = oRdDataOut.Rdy & !empty.
REQ-017 The block SHALL pop the head on a data handshake with last == 1; non-last beats SHALL NOT change FIFO state.
REQ-018 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-019 When the FIFO is empty, a pushed entry SHALL become visible on oRdDataOut.Dst and unblock data on the next cycle (1-cycle latency, no bypass).
REQ-020 When the FIFO is full, a same-cycle pop SHALL NOT raise iRdCmdIn.Rdy in that cycle; there is no combinational path from the data side to command Rdy.
REQ-021 The block SHALL register oOcc, equal to count.
REQ-022 Payloads SHALL pass through combinationally, with zero latency and no modification.

Reset
REQ-023 On iRst_n low, the block SHALL clear pointers, count, oOcc and oOrphanErr to 0 and clear FIFO contents to 0, so oRdDataOut.Dst = 0.
REQ-024 During reset, oRdDataOut.Vld SHALL be 0 (empty); reset mid-burst SHALL discard all outstanding entries.

Configuration
REQ-025 Macro RD_DST_ORPHAN_DROP_EN defined: the block SHALL accept a data beat arriving while empty (iRdDataIn.Rdy = 1), SHALL NOT forward it (oRdDataOut.Vld = 0), and SHALL set oOrphanErr until reset.
REQ-026 Macro undefined: orphan data SHALL stall (iRdDataIn.Rdy = 0) until an entry exists, and port oOrphanErr SHALL be absent.

Structure
REQ-027 The command payload field widths and a packed command-payload struct SHALL live in the shared switch package, with DST_W default 4.
REQ-028 The destination FIFO SHALL be a sub-module, rd_dst_fifo (push/pop/head/full/empty/count), instantiated once.

Verification
REQ-029 Cmd dst=3, drop=0, then 4-beat burst with last on beat 4 -> all beats Dst=3; oOcc goes 1 -> 0 after beat 4.
REQ-030 DEPTH=4: 5 commands back to back, dst 1..5, data stalled -> 4 accepted, 5th held with iRdCmdIn.Rdy=0; after the first burst's last beat, the 5th is accepted the next cycle; bursts emerge with Dst 1,2,3,4,5.
REQ-031 Cmd drop=1 dst=7 -> oRdCmdOut.Vld=1, oOcc stays 0, data remains blocked.
REQ-032 Full FIFO, last-beat pop and a new cmd in the same cycle -> cmd Rdy=0 that cycle, accepted the next cycle, oOcc returns to 4.
REQ-033 Data beat while empty -> macro on: beat consumed, oOrphanErr=1 sticky; macro off: iRdDataIn.Rdy=0 until a cmd is pushed.
REQ-034 Async reset asserted with oOcc=3 mid-burst -> oOcc=0, oRdDataOut.Vld=0 and Dst=0 immediately.
